fifo_uart_tx: RTL and testbench

- Read-side consumer for the team's 8-bit FIFO.
- Runs in the FIFO's read clock domain. Pops one byte whenever the FIFO is non-empty and the block is enabled.
- Serializes each popped byte as a UART 8N1 frame on `tx`.
- Connects directly to the FIFO `rd`, `data_out` and `empty` pins. This is the drain path from the FIFO to an off-chip serial link.

---
 rtl/fifo_uart_tx_if.sv | 11 +
 rtl/fifo_uart_tx.sv | 131 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Read-side connection between the 8-bit FIFO and its UART drain.
// Handshake: rd is a one-cycle strobe raised only while empty=0. The FIFO pops on the edge that samples rd=1,
// and fifo_data holds the popped byte from the cycle after that edge.
interface fifo_uart_tx_if;
    logic       rd;
    logic       empty;
    logic [7:0] fifo_data;

    modport master (output rd, input empty, input fifo_data);
    modport slave  (input rd, output empty, output fifo_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the FIFO read port and sends each one as a UART 8N1 frame on tx.
// Each pop moves through IDLE, WAIT and LOAD before the start bit, so back-to-back frames have a fixed 3-cycle gap.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  rd_clk,
    input  logic                  reset_n,
    input  logic                  enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_nxt;
    logic [15:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        tx_nxt, rd_nxt, frame_done_nxt;
    logic        baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable && !fifo.empty) state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_START;
            S_START: if (baud_last) state_nxt = S_DATA;
            S_DATA:  if (baud_last && bit_cnt == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (baud_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and datapath: tx, rd and frame_done all change on the clock edge.
    always_comb begin
        rd_nxt         = 1'b0;
        tx_nxt         = tx;
        frame_done_nxt = 1'b0;
        baud_cnt_nxt   = baud_cnt;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (enable && !fifo.empty) rd_nxt = 1'b1;
            end
            S_WAIT: begin
                tx_nxt = 1'b1;
            end
            S_LOAD: begin
                shift_nxt    = fifo.fifo_data;
                tx_nxt       = 1'b0;
                baud_cnt_nxt = 16'd0;
            end
            S_START: begin
                if (baud_last) begin
                    baud_cnt_nxt = 16'd0;
                    bit_cnt_nxt  = 3'd0;
                    tx_nxt       = shift[0];
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_cnt_nxt = 16'd0;
                    if (bit_cnt == 3'd7) begin
                        tx_nxt = 1'b1;
                    end else begin
                        shift_nxt   = {1'b0, shift[7:1]};
                        tx_nxt      = shift[1];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                tx_nxt = 1'b1;
                if (baud_last) begin
                    baud_cnt_nxt   = 16'd0;
                    frame_done_nxt = 1'b1;
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx         <= 1'b1;
            fifo.rd    <= 1'b0;
            frame_done <= 1'b0;
            baud_cnt   <= 16'd0;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
        end else begin
            tx         <= tx_nxt;
            fifo.rd    <= rd_nxt;
            frame_done <= frame_done_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds bytes, and a UART receiver on tx checks frames against an expected-byte queue.
module tb_fifo_uart_tx;

    localparam int C = 4;

    logic rd_clk;
    logic reset_n;
    logic enable;
    logic tx, busy, frame_done;
    logic [2:0] dbg_state;

    fifo_uart_tx_if fifo_bus();

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .rd_clk     (rd_clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fifo       (fifo_bus),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // FIFO model: stimulus writes push_q, and this process owns the FIFO contents and flags
    logic [7:0] push_q[$];
    logic [7:0] fifo_q[$];
    logic       rst_prev = 1'b0;

    always @(posedge rd_clk) begin
        if (!reset_n && rst_prev) fifo_q.delete();
        rst_prev <= reset_n;
        while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
        if (reset_n && fifo_bus.rd && fifo_q.size() > 0)
            fifo_bus.fifo_data <= fifo_q.pop_front();
        fifo_bus.empty <= (fifo_q.size() == 0);
    end

    // scoreboard state
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // monitor: UART receiver and timing checks, sampled on the falling edge
    int cyc = 0;
    int rd_pulses = 0;
    int done_cnt = 0;
    int frames_rx = 0;
    int rd_cycle = 0, start_cycle = 0, done_cycle = 0, gap_last = 0;
    bit rd_prev = 1'b0;
    bit rx_active = 1'b0;
    int rx_idx = 0;
    logic [7:0] rx_byte = 8'd0;

    initial begin : monitor
        int k;
        forever begin
            @(negedge rd_clk);
            cyc++;
            if (!reset_n) begin
                rx_active = 1'b0;
                rd_prev   = 1'b0;
                continue;
            end
            if (fifo_bus.rd) begin
                chk("rd_single_cycle", int'(rd_prev), 0);
                if (!rd_prev) begin
                    rd_pulses++;
                    rd_cycle = cyc;
                end
            end
            rd_prev = fifo_bus.rd;
            if (frame_done) begin
                chk("frame_done_latency", cyc - start_cycle, 10 * C);
                done_cnt++;
                done_cycle = cyc;
            end
            if (!rx_active && tx == 1'b0) begin
                rx_active   = 1'b1;
                rx_idx      = 0;
                start_cycle = cyc;
                gap_last    = cyc - done_cycle;
                chk("rd_to_start_fall", cyc - rd_cycle, 2);
            end
            if (rx_active) begin
                if (rx_idx % C == C / 2) begin
                    k = rx_idx / C;
                    if (k == 0) begin
                        chk("start_bit", int'(tx), 0);
                    end else if (k <= 8) begin
                        rx_byte[k-1] = tx;
                    end else begin
                        chk("stop_bit", int'(tx), 1);
                        if (exp_q.size() == 0) chk("frame_expected", 0, 1);
                        else chk("rx_byte", int'(rx_byte), int'(exp_q.pop_front()));
                        frames_rx++;
                        rx_active = 1'b0;
                    end
                end
                rx_idx++;
            end
        end
    end

    // driver tasks
    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        push_q.push_back(b);
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic wait_done(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge rd_clk);
            if (done_cnt >= target) break;
        end
        if (i == budget) chk("wait_done_timeout", done_cnt, target);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge rd_clk);
            if (dbg_state == st) break;
        end
        if (i == budget) chk("wait_state_timeout", int'(dbg_state), int'(st));
    endtask

    // stimulus
    initial begin : stimulus
        int viol;
        int rd_base;
        reset_n = 1'b0;
        enable  = 1'b1;
        push_byte(8'hA5, 1'b1);

        // reset holds outputs quiet even with data available and enable high
        repeat (6) begin
            @(negedge rd_clk);
            chk("reset_tx", int'(tx), 1);
            chk("reset_rd", int'(fifo_bus.rd), 0);
            chk("reset_busy", int'(busy), 0);
        end
        chk("reset_state", int'(dbg_state), 0);
        reset_n = 1'b1;
        @(negedge rd_clk);
        chk("rd_after_release", int'(fifo_bus.rd), 1);

        // single byte 0xA5, then an idle FIFO for 100 cycles
        wait_done(1, 200);
        @(negedge rd_clk);
        chk("busy_after_frame", int'(busy), 0);
        rd_base = rd_pulses;
        viol = 0;
        repeat (100) begin
            @(negedge rd_clk);
            if (fifo_bus.rd || !tx || busy) viol++;
        end
        chk("empty_idle_quiet", viol, 0);
        chk("empty_no_rd", rd_pulses - rd_base, 0);

        // back-to-back 0x00 then 0xFF
        rd_base = rd_pulses;
        push_byte(8'h00, 1'b1);
        push_byte(8'hFF, 1'b1);
        wait_done(3, 300);
        chk("b2b_gap", gap_last, 3);
        repeat (5) @(negedge rd_clk);
        chk("b2b_rd_pulses", rd_pulses - rd_base, 2);

        // enable dropped during DATA of the first of three queued bytes
        rd_base = rd_pulses;
        push_byte(8'h12, 1'b1);
        push_byte(8'h34, 1'b1);
        push_byte(8'h56, 1'b1);
        wait_state(3'd4, 50);
        enable = 1'b0;
        wait_done(4, 200);
        repeat (20) @(negedge rd_clk);
        chk("en_low_rd_pulses", rd_pulses - rd_base, 1);
        chk("en_low_busy", int'(busy), 0);
        enable = 1'b1;
        @(negedge rd_clk);
        chk("en_resume_rd", int'(fifo_bus.rd), 1);
        wait_done(6, 300);

        // reset mid-DATA (bit 3): the in-flight byte is discarded
        push_byte(8'h99, 1'b0);
        wait_state(3'd3, 50);
        repeat (4 * C + 1) @(negedge rd_clk);
        chk("pre_reset_in_data", int'(dbg_state), 4);
        @(posedge rd_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_tx", int'(tx), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_state", int'(dbg_state), 0);
        repeat (3) @(negedge rd_clk);
        reset_n = 1'b1;
        push_byte(8'h3C, 1'b1);
        wait_done(7, 200);
        repeat (5) @(negedge rd_clk);

        chk("frames_received", frames_rx, 7);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
